// File: rtl/wb_timer.sv
// Wishbone classic 64-bit machine timer (MTIME/MTIMECMP) with a level interrupt.
// Define WB_TIMER_PRESCALER_EN to include the 16-bit prescaler and PRESCALE register.
module wb_timer #(
    parameter logic [15:0] PRESCALE_RESET = 16'h0000,
    parameter logic [63:0] CMP_RESET      = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [2:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        irq_o
);

    logic        req;
    logic        wr;
    logic [31:0] byte_mask;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [63:0] mtime_inc;
    logic        en;
    logic        irq_en;
    logic        match;
    logic        tick;
    logic [15:0] prescale;
    logic [31:0] rdata;

    // A new request is only accepted once the previous response has retired.
    assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign wr        = req & wb_we_i;
    assign byte_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign mtime_inc = mtime + {63'd0, tick};

`ifdef WB_TIMER_PRESCALER_EN
    logic [15:0] pcount;
    logic        prescale_wr;
    logic        en_clr;

    assign prescale_wr = wr && (wb_adr_i == 3'd5);
    assign en_clr      = wr && (wb_adr_i == 3'd4) && wb_sel_i[0] && !wb_dat_i[0];
    assign tick        = en && (pcount == prescale);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            prescale <= PRESCALE_RESET;
            pcount   <= 16'd0;
        end else begin
            if (prescale_wr) begin
                prescale <= (prescale & ~byte_mask[15:0]) | (wb_dat_i[15:0] & byte_mask[15:0]);
            end
            if (prescale_wr || en_clr) begin
                pcount <= 16'd0;
            end else if (en) begin
                pcount <= tick ? 16'd0 : pcount + 16'd1;
            end
        end
    end
`else
    // Without the prescaler the register reads as zero and the parameter has no effect.
    assign prescale = PRESCALE_RESET & 16'h0000;
    assign tick     = en;
`endif

    always_comb begin
        rdata = 32'h0;
        case (wb_adr_i)
            3'd0:    rdata = mtime[31:0];
            3'd1:    rdata = mtime[63:32];
            3'd2:    rdata = mtimecmp[31:0];
            3'd3:    rdata = mtimecmp[63:32];
            3'd4:    rdata = {30'h0, irq_en, en};
            3'd5:    rdata = {16'h0, prescale};
            3'd6:    rdata = {31'h0, match};
            default: rdata = 32'h0;
        endcase
    end

    // Written MTIME bytes override the tick; unwritten bytes still advance.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            mtime    <= 64'd0;
            mtimecmp <= CMP_RESET;
            en       <= 1'b0;
            irq_en   <= 1'b0;
            match    <= 1'b0;
            irq_o    <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= 32'h0;
        end else begin
            mtime <= mtime_inc;
            if (wr && (wb_adr_i == 3'd0)) begin
                mtime[31:0] <= (mtime_inc[31:0] & ~byte_mask) | (wb_dat_i & byte_mask);
            end
            if (wr && (wb_adr_i == 3'd1)) begin
                mtime[63:32] <= (mtime_inc[63:32] & ~byte_mask) | (wb_dat_i & byte_mask);
            end
            if (wr && (wb_adr_i == 3'd2)) begin
                mtimecmp[31:0] <= (mtimecmp[31:0] & ~byte_mask) | (wb_dat_i & byte_mask);
            end
            if (wr && (wb_adr_i == 3'd3)) begin
                mtimecmp[63:32] <= (mtimecmp[63:32] & ~byte_mask) | (wb_dat_i & byte_mask);
            end
            if (wr && (wb_adr_i == 3'd4) && wb_sel_i[0]) begin
                en     <= wb_dat_i[0];
                irq_en <= wb_dat_i[1];
            end

            match <= (mtime >= mtimecmp);
            irq_o <= (mtime >= mtimecmp) & irq_en;

            wb_ack_o <= req && (wb_adr_i != 3'd7);
            wb_err_o <= req && (wb_adr_i == 3'd7);
            wb_dat_o <= (req && (wb_adr_i != 3'd7)) ? rdata : 32'h0;
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// Directed self-checking bench for wb_timer; expected responses go through a scoreboard queue.
// Honours WB_TIMER_PRESCALER_EN the same way as the design.
module tb_wb_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [31:0] dat_o;
    logic        ack;
    logic        err;
    logic        irq;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        string       tag;
        logic        ack;
        logic        err;
        logic [31:0] dat;
        bit          dat_valid;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    wb_timer dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_dat_o (dat_o),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .irq_o    (irq)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One Wishbone access: expectation queued at drive time, popped when the response is due.
    task automatic applyStimulus(input string tag, input logic [2:0] a, input logic w,
                                 input logic [31:0] d, input logic [3:0] s,
                                 input bit dv, input logic [31:0] ed,
                                 output logic [31:0] rd, output logic irq_ack);
        exp_t e;
        e.tag       = tag;
        e.ack       = (a != 3'd7);
        e.err       = (a == 3'd7);
        e.dat       = (a == 3'd7) ? 32'h0 : ed;
        e.dat_valid = dv || (a == 3'd7);
        sb.push_back(e);
        adr = a; we = w; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        e = sb.pop_front();
        checkOutput({e.tag, "_ack"}, ack, e.ack);
        checkOutput({e.tag, "_err"}, err, e.err);
        if (e.dat_valid) checkOutput({e.tag, "_dat"}, dat_o, e.dat);
        rd      = dat_o;
        irq_ack = irq;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        checkOutput({e.tag, "_resp_width"}, {ack, err}, 2'b00);
        checkOutput({e.tag, "_dat_idle"}, dat_o, 32'h0);
    endtask

    task automatic wbWrite(input string tag, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        logic        ia;
        applyStimulus(tag, a, 1'b1, d, s, 1'b0, 32'h0, rd, ia);
    endtask

    task automatic wbRead(input string tag, input logic [2:0] a, input logic [31:0] ed);
        logic [31:0] rd;
        logic        ia;
        applyStimulus(tag, a, 1'b0, 32'h0, 4'hF, 1'b1, ed, rd, ia);
    endtask

    task automatic wbPeek(input string tag, input logic [2:0] a, output logic [31:0] rd);
        logic ia;
        applyStimulus(tag, a, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0, rd, ia);
    endtask

    initial begin
        logic [31:0] exp_rst [7];
        logic [31:0] rd;
        logic        ia;
        int          c;
        int unsigned exp_time;
        logic [31:0] exp_prescale;

        exp_rst = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
`ifdef WB_TIMER_PRESCALER_EN
        exp_time     = 10;
        exp_prescale = 32'd3;
`else
        exp_time     = 40;
        exp_prescale = 32'd0;
`endif

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 3'd0; dat_i = 32'h0; sel = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {ack, err, irq, dat_o}, 35'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] register reset values");
        for (int i = 0; i < 7; i++) begin
            wbRead($sformatf("reset_read%0d", i), 3'(i), exp_rst[i]);
        end

        $display("[TB] prescaled counting");
        wbWrite("wr_prescale", 3'd5, 32'd3, 4'hF);
        wbWrite("wr_ctrl_en", 3'd4, 32'd1, 4'hF);
        repeat (40) @(posedge clk);
        #1;
        wbPeek("rd_mtime_pre", 3'd0, rd);
        checkOutput("mtime_after_40", (rd >= exp_time - 1) && (rd <= exp_time + 1), 1'b1);
        wbRead("rd_prescale", 3'd5, exp_prescale);
        wbWrite("wr_ctrl_off", 3'd4, 32'd0, 4'hF);

        $display("[TB] low-word carry and 64-bit wrap");
        wbWrite("wr_mtime_lo", 3'd0, 32'hFFFF_FFFE, 4'hF);
        wbWrite("wr_mtime_hi", 3'd1, 32'h0, 4'hF);
        wbWrite("wr_prescale0", 3'd5, 32'd0, 4'hF);
        wbWrite("wr_ctrl_run", 3'd4, 32'd1, 4'hF);
        wbRead("carry_hi_before", 3'd1, 32'd0);
        wbRead("carry_hi_after", 3'd1, 32'd1);
        wbWrite("wr_ctrl_stop", 3'd4, 32'd0, 4'hF);
        wbWrite("wr_mtime_lo_max", 3'd0, 32'hFFFF_FFFF, 4'hF);
        wbWrite("wr_mtime_hi_max", 3'd1, 32'hFFFF_FFFF, 4'hF);
        wbWrite("wr_ctrl_run2", 3'd4, 32'd1, 4'hF);
        wbRead("wrap_hi", 3'd1, 32'd0);
        wbRead("wrap_lo", 3'd0, 32'd2);

        $display("[TB] compare and interrupt");
        wbWrite("wr_ctrl_stop2", 3'd4, 32'd0, 4'hF);
        wbWrite("wr_cmp_hi", 3'd3, 32'd0, 4'hF);
        wbWrite("wr_cmp_lo", 3'd2, 32'd100, 4'hF);
        wbWrite("wr_mtime_lo0", 3'd0, 32'd0, 4'hF);
        wbWrite("wr_mtime_hi0", 3'd1, 32'd0, 4'hF);
        wbWrite("wr_ctrl_irq", 3'd4, 32'd3, 4'hF);
        c = 1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            c++;
            if (irq === 1'b1) break;
        end
        checkOutput("irq_rise_cycle", c, 101);
        wbRead("status_match", 3'd6, 32'd1);
        applyStimulus("wr_cmp_1000", 3'd2, 1'b1, 32'd1000, 4'hF, 1'b0, 32'h0, rd, ia);
        checkOutput("irq_during_ack", ia, 1'b1);
        checkOutput("irq_after_rewrite", irq, 1'b0);
        wbRead("status_clear", 3'd6, 32'd0);

        $display("[TB] error response and byte lanes");
        wbWrite("wr_ctrl_stop3", 3'd4, 32'd0, 4'hF);
        wbWrite("wr_mtime_pat", 3'd0, 32'h1234_5600, 4'hF);
        wbWrite("wr_addr7", 3'd7, 32'hFFFF_FFFF, 4'hF);
        wbRead("rd_addr7", 3'd7, 32'h0);
        wbRead("mtime_unchanged", 3'd0, 32'h1234_5600);
        wbRead("ctrl_unchanged", 3'd4, 32'd0);
        wbWrite("wr_byte0", 3'd0, 32'h0000_00AB, 4'b0001);
        wbRead("mtime_byte0", 3'd0, 32'h1234_56AB);
        wbWrite("wr_ctrl_unused", 3'd4, 32'hFFFF_FFFE, 4'hF);
        wbRead("ctrl_unused_bits", 3'd4, 32'd2);

        // Strobe held across accesses must still see an idle cycle between acks.
        adr = 3'd4; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        checkOutput("b2b_ack1", ack, 1'b1);
        @(posedge clk); #1;
        checkOutput("b2b_idle", ack, 1'b0);
        @(posedge clk); #1;
        checkOutput("b2b_ack2", ack, 1'b1);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;

        $display("[TB] reset during pending write");
        checkOutput("irq_before_reset", irq, 1'b1);
        adr = 3'd4; we = 1'b1; dat_i = 32'd3; sel = 4'hF; cyc = 1'b1; stb = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_mid_ack", {ack, err}, 2'b00);
        checkOutput("rst_mid_irq", irq, 1'b0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_after_ack", {ack, err, irq}, 3'b000);
        wbRead("ctrl_after_rst", 3'd4, 32'd0);
        wbRead("cmp_after_rst", 3'd2, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
